seq_rca: RTL and testbench

Parametrised, multi-cycle ripple-carry adder/subtractor. Each cycle it adds one CHUNK-bit slice of the operands through a CHUNK-bit ripple chain and keeps the carry in a register between slices. Operands enter and results leave through valid/ready handshakes, so it can sit between sequential datapath stages. It trades latency for a short carry chain.

---
 rtl/seq_rca.sv | 219 +++++++++++++++++++++
 tb/tb_seq_rca.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_rca.sv
// rtl/seq_rca.sv - multi-cycle ripple-carry adder/subtractor with valid/ready handshakes
//
// Purpose:
//   Adds or subtracts two WIDTH-bit operands CHUNK bits per clock through a
//   CHUNK-bit ripple chain. The carry is held in a register between slices.
//   A result is produced WIDTH/CHUNK clocks after the operands are accepted.
//
// Parameters:
//   WIDTH  operand/result width in bits (default 8)
//   CHUNK  bits added per clock (default 2); must divide WIDTH
//
// Optional feature:
//   SEQ_RCA_OVF_EN  when defined, adds output ovf, the two's-complement
//                   overflow flag of the completed add or subtract.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand set valid
//   in_ready   out  block can accept operands (high only in IDLE)
//   a          in   operand A [WIDTH]
//   b          in   operand B [WIDTH]
//   cin        in   carry-in (borrow-in when sub=1)
//   sub        in   0: a+b+cin, 1: a-b-cin
//   out_valid  out  result valid (high only in DONE)
//   out_ready  in   consumer accepts the result
//   sum        out  result [WIDTH]
//   cout       out  final carry-out (1 = no borrow when subtracting)
//   ovf        out  signed overflow (only with SEQ_RCA_OVF_EN)

module seq_rca #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_SLICE = CW'(NCH - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("seq_rca: CHUNK must satisfy 1 <= CHUNK <= WIDTH and divide WIDTH");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SEQ_RCA_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // ---------------------------------------------------------------------
  // Slice selection: pick the CHUNK-bit window addressed by the counter.
  // ---------------------------------------------------------------------
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cnt_q == CW'(k)) begin
        a_sl = a_q[k*CHUNK +: CHUNK];
        b_sl = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // ---------------------------------------------------------------------
  // CHUNK chained full adders. c_chain[i] is the carry into bit i of the
  // slice; c_chain[CHUNK] leaves the slice. c_chain[CHUNK-1] is the carry
  // into the slice MSB, which on the last slice is the carry into the
  // word MSB used for signed overflow.
  // ---------------------------------------------------------------------
  logic [CHUNK:0]   c_chain;
  logic [CHUNK-1:0] s_sl;

  always_comb begin
    c_chain    = '0;
    s_sl       = '0;
    c_chain[0] = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      s_sl[i]      = a_sl[i] ^ b_sl[i] ^ c_chain[i];
      c_chain[i+1] = (a_sl[i] & b_sl[i]) | (c_chain[i] & (a_sl[i] ^ b_sl[i]));
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SEQ_RCA_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1 - cin, so invert B once here and
          // seed the carry with ~cin; the slices then only ever add.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        for (int k = 0; k < NCH; k++) begin
          if (cnt_q == CW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = s_sl;
          end
        end
        carry_d = c_chain[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_SLICE) begin
          cout_d  = c_chain[CHUNK];
`ifdef SEQ_RCA_OVF_EN
          ovf_d   = c_chain[CHUNK-1] ^ c_chain[CHUNK];
`endif
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Result registers are left untouched so they hold through
        // backpressure and remain readable after the handshake.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SEQ_RCA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SEQ_RCA_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. Handshake flags decode the state directly so in_ready is
  // already high while reset is held.
  // ---------------------------------------------------------------------
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SEQ_RCA_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_rca.sv
// tb/tb_seq_rca.sv - directed and random checks of seq_rca at CHUNK=2, 1 and 8

module tb_seq_rca;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Index 0: CHUNK=2, index 1: CHUNK=1, index 2: CHUNK=8 (all WIDTH=8).
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] a_s       [3];
  logic [7:0] b_s       [3];
  logic       cin_s     [3];
  logic       sub_s     [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] sum_o     [3];
  logic       cout_o    [3];
`ifdef SEQ_RCA_OVF_EN
  logic       ovf_o     [3];
  logic       r_ovf;
`endif

  int         checks = 0;
  int         errors = 0;

  logic [7:0] r_sum;
  logic       r_cout;
  int         r_lat;

  seq_rca #(.WIDTH(8), .CHUNK(2)) u_c2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .sub(sub_s[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum_o[0]), .cout(cout_o[0])
`ifdef SEQ_RCA_OVF_EN
    , .ovf(ovf_o[0])
`endif
  );

  seq_rca #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]), .sub(sub_s[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum_o[1]), .cout(cout_o[1])
`ifdef SEQ_RCA_OVF_EN
    , .ovf(ovf_o[1])
`endif
  );

  seq_rca #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]), .sub(sub_s[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum_o[2]), .cout(cout_o[2])
`ifdef SEQ_RCA_OVF_EN
    , .ovf(ovf_o[2])
`endif
  );

  // Runs one operation on instance d with out_ready held high. Leaves the
  // result in r_sum/r_cout(/r_ovf) and the accept-to-out_valid edge count
  // in r_lat. Operands are scrambled right after acceptance.
  task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic su);
    int n;
    @(negedge clk);
    out_ready[d] = 1'b1;
    a_s[d] = x; b_s[d] = y; cin_s[d] = ci; sub_s[d] = su;
    in_valid[d] = 1'b1;
    n = 0;
    while (in_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut=%0d in_ready=%b required 1", d, in_ready[d]);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    a_s[d] = 8'($urandom); b_s[d] = 8'($urandom);
    cin_s[d] = 1'($urandom); sub_s[d] = 1'($urandom);
    r_lat = 0;
    while (out_valid[d] !== 1'b1 && r_lat < 50) begin
      @(posedge clk); #1;
      r_lat++;
    end
    if (r_lat >= 50) begin
      checks++; errors++;
      $display("FAIL result_timeout dut=%0d out_valid=%b required 1", d, out_valid[d]);
    end
    r_sum  = sum_o[d];
    r_cout = cout_o[d];
`ifdef SEQ_RCA_OVF_EN
    r_ovf  = ovf_o[d];
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        in_valid[d] = 1'($urandom); out_ready[d] = 1'($urandom);
        a_s[d] = 8'($urandom); b_s[d] = 8'($urandom);
        cin_s[d] = 1'($urandom); sub_s[d] = 1'($urandom);
      end
      #2;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({in_ready[d], out_valid[d], sum_o[d], cout_o[d]} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
          errors++;
          $display("FAIL reset_hold dut=%0d in_ready=%b out_valid=%b sum=%h cout=%b required 1 0 00 0",
                   d, in_ready[d], out_valid[d], sum_o[d], cout_o[d]);
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({in_ready[d], out_valid[d], sum_o[d], cout_o[d]} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL reset_release dut=%0d in_ready=%b out_valid=%b sum=%h cout=%b required 1 0 00 0",
                 d, in_ready[d], out_valid[d], sum_o[d], cout_o[d]);
      end
    end
  endtask

  task automatic test_add();
    run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    checks++;
    if ({r_sum, r_cout} !== {8'h96, 1'b0}) begin
      errors++; $display("FAIL add_5a_3c sum=%h cout=%b required 96 0", r_sum, r_cout);
    end
    checks++;
    if (r_lat !== 4) begin
      errors++; $display("FAIL add_latency got=%0d required 4", r_lat);
    end
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    checks++;
    if ({r_sum, r_cout} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL add_ff_01 sum=%h cout=%b required 00 1", r_sum, r_cout);
    end
`ifdef SEQ_RCA_OVF_EN
    checks++;
    if (r_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_ff_01 got=%b required 0", r_ovf);
    end
`endif
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    checks++;
    if ({r_sum, r_cout} !== {8'h80, 1'b0}) begin
      errors++; $display("FAIL add_7f_01 sum=%h cout=%b required 80 0", r_sum, r_cout);
    end
`ifdef SEQ_RCA_OVF_EN
    checks++;
    if (r_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_7f_01 got=%b required 1", r_ovf);
    end
`endif
  endtask

  task automatic test_sub();
    run_op(0, 8'h10, 8'h20, 1'b0, 1'b1);
    checks++;
    if ({r_sum, r_cout} !== {8'hF0, 1'b0}) begin
      errors++; $display("FAIL sub_10_20 sum=%h cout=%b required f0 0", r_sum, r_cout);
    end
    run_op(0, 8'h20, 8'h10, 1'b0, 1'b1);
    checks++;
    if ({r_sum, r_cout} !== {8'h10, 1'b1}) begin
      errors++; $display("FAIL sub_20_10 sum=%h cout=%b required 10 1", r_sum, r_cout);
    end
    run_op(0, 8'h20, 8'h10, 1'b1, 1'b1);
    checks++;
    if ({r_sum, r_cout} !== {8'h0F, 1'b1}) begin
      errors++; $display("FAIL sub_borrow sum=%h cout=%b required 0f 1", r_sum, r_cout);
    end
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1);
    checks++;
    if ({r_sum, r_cout} !== {8'h7F, 1'b1}) begin
      errors++; $display("FAIL sub_80_01 sum=%h cout=%b required 7f 1", r_sum, r_cout);
    end
`ifdef SEQ_RCA_OVF_EN
    checks++;
    if (r_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sub_80_01 got=%b required 1", r_ovf);
    end
`endif
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    out_ready[0] = 1'b0;
    a_s[0] = 8'h33; b_s[0] = 8'h44; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n = 0;
    while (out_valid[0] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if ({out_valid[0], sum_o[0], cout_o[0]} !== {1'b1, 8'h77, 1'b0}) begin
      errors++;
      $display("FAIL bp_result out_valid=%b sum=%h cout=%b required 1 77 0", out_valid[0], sum_o[0], cout_o[0]);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_s[0] = 8'($urandom); b_s[0] = 8'($urandom);
      in_valid[0] = c[0];
      @(posedge clk); #1;
      checks++;
      if ({out_valid[0], in_ready[0], sum_o[0], cout_o[0]} !== {1'b1, 1'b0, 8'h77, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d out_valid=%b in_ready=%b sum=%h cout=%b required 1 0 77 0",
                 c, out_valid[0], in_ready[0], sum_o[0], cout_o[0]);
      end
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid[0], in_ready[0], sum_o[0], cout_o[0]} !== {1'b0, 1'b1, 8'h77, 1'b0}) begin
      errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b sum=%h cout=%b required 0 1 77 0",
               out_valid[0], in_ready[0], sum_o[0], cout_o[0]);
    end
    run_op(0, 8'h12, 8'h34, 1'b0, 1'b0);
    checks++;
    if ({r_sum, r_cout} !== {8'h46, 1'b0}) begin
      errors++; $display("FAIL bp_next_op sum=%h cout=%b required 46 0", r_sum, r_cout);
    end
  endtask

  task automatic test_abort();
    int pulses;
    @(negedge clk);
    out_ready[0] = 1'b1;
    a_s[0] = 8'h0F; b_s[0] = 8'h0F; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++; $display("FAIL abort_in_run in_ready=%b required 0", in_ready[0]);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready[0], out_valid[0], sum_o[0], cout_o[0]} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL abort_async in_ready=%b out_valid=%b sum=%h cout=%b required 1 0 00 0",
               in_ready[0], out_valid[0], sum_o[0], cout_o[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_pulse pulses=%0d in_ready=%b required 0 1", pulses, in_ready[0]);
    end
    run_op(0, 8'h01, 8'h01, 1'b0, 1'b0);
    checks++;
    if ({r_sum, r_cout} !== {8'h02, 1'b0}) begin
      errors++; $display("FAIL abort_next_op sum=%h cout=%b required 02 0", r_sum, r_cout);
    end
  endtask

  task automatic test_back_to_back();
    int edge_n;
    int first;
    int second;
    @(negedge clk);
    out_ready[0] = 1'b1;
    a_s[0] = 8'h03; b_s[0] = 8'h04; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
    in_valid[0] = 1'b1;
    first = -1; second = -1;
    for (edge_n = 1; edge_n <= 40 && second < 0; edge_n++) begin
      @(posedge clk); #1;
      if (out_valid[0] === 1'b1) begin
        checks++;
        if (sum_o[0] !== 8'h07) begin
          errors++; $display("FAIL b2b_sum edge=%0d sum=%h required 07", edge_n, sum_o[0]);
        end
        if (first < 0) first = edge_n;
        else second = edge_n;
      end
    end
    in_valid[0] = 1'b0;
    checks++;
    if (second - first !== 6) begin
      errors++; $display("FAIL b2b_period got=%0d required 6", second - first);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_chunk_sizes();
    run_op(1, 8'hAA, 8'h55, 1'b1, 1'b0);
    checks++;
    if ({r_sum, r_cout, r_lat} !== {8'h00, 1'b1, 32'd8}) begin
      errors++; $display("FAIL chunk1 sum=%h cout=%b lat=%0d required 00 1 8", r_sum, r_cout, r_lat);
    end
    run_op(2, 8'hAA, 8'h55, 1'b1, 1'b0);
    checks++;
    if ({r_sum, r_cout, r_lat} !== {8'h00, 1'b1, 32'd1}) begin
      errors++; $display("FAIL chunk8 sum=%h cout=%b lat=%0d required 00 1 1", r_sum, r_cout, r_lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] x, y, ye;
    logic       ci, su;
    logic [8:0] ref_v;
    for (int d = 1; d < 3; d++) begin
      for (int n = 0; n < 500; n++) begin
        x = 8'($urandom); y = 8'($urandom);
        ci = 1'($urandom); su = 1'($urandom);
        ye = su ? ~y : y;
        ref_v = {1'b0, x} + {1'b0, ye} + {8'd0, ci ^ su};
        run_op(d, x, y, ci, su);
        checks++;
        if ({r_cout, r_sum} !== ref_v) begin
          errors++;
          $display("FAIL random dut=%0d a=%h b=%h cin=%b sub=%b got=%b_%h required %b_%h",
                   d, x, y, ci, su, r_cout, r_sum, ref_v[8], ref_v[7:0]);
        end
`ifdef SEQ_RCA_OVF_EN
        checks++;
        if (r_ovf !== ((x[7] == ye[7]) && (ref_v[7] != x[7]))) begin
          errors++;
          $display("FAIL random_ovf dut=%0d a=%h b=%h sub=%b got=%b", d, x, y, su, r_ovf);
        end
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1;
      a_s[d] = '0; b_s[d] = '0; cin_s[d] = 1'b0; sub_s[d] = 1'b0;
    end
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_chunk_sizes();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
